inst_cache_ctrl: RTL and testbench
==================================

// Module: inst_cache_ctrl
// PURPOSE
//  Direct-mapped instruction-cache controller. Drives the tag RAM (inst_cache_tag) and the
//  I-cache data RAM. Accepts fetch requests from the CPU fetch stage and compares tags for
//  hit/miss. Refills one line from memory on a miss and invalidates all lines on a flush.
//  Sits between the fetch stage and the instruction-memory port.
// PARAMETERS
//  ADDR_W  32  fetch/memory address width (byte address)
//  DATA_W  32  instruction / line width (one word per line)
//  CNT_W   32  width of hit/miss performance counters
//  Index/tag widths: `ICACHE_INDEX, `ITAGMSB, `ITAGLSB, `ICACHE_SIZE from config.sv
// PORTS
//  clk            in   1             clock; all state changes on posedge
//  rst            in   1             synchronous reset, active-high
//  cpu_req_valid  in   1             fetch request valid
//  cpu_req_ready  out  1             controller accepts request this cycle
//  cpu_req_addr   in   ADDR_W        fetch byte address
//  cpu_resp_valid out  1             one-cycle pulse: cpu_resp_data valid
//  cpu_resp_data  out  DATA_W        fetched instruction
//  flush_req      in   1             invalidate entire cache
//  flush_done     out  1             one-cycle pulse when flush completes
//  tag_we         out  1             tag RAM write enable
//  tag_index      out  `ICACHE_INDEX   tag/data RAM index
//  tag_valid_in   out  1             valid bit to write
//  tag_in         out  TAG           tag to write ([`ITAGMSB:`ITAGLSB])
//  tag_valid_out  in   1             valid bit read at tag_index (combinational)
//  tag_out        in   TAG           tag read at tag_index (combinational)
//  dat_we         out  1             data RAM write enable
//  dat_wdata      out  DATA_W        data RAM write data
//  dat_rdata      in   DATA_W        data RAM read at tag_index (combinational)
//  mem_req        out  1             memory read request, held until mem_ack
//  mem_addr       out  ADDR_W        word-aligned line address
//  mem_ack        in   1             memory read complete; mem_rdata valid this cycle
//  mem_rdata      in   DATA_W        memory read data
//  hit_cnt        out  CNT_W         saturating hit counter
//  miss_cnt       out  CNT_W         saturating miss counter
// BEHAVIOUR
//  Address split: tag = addr[`ITAGMSB:`ITAGLSB]; index = addr[`ITAGLSB-1 -: `ICACHE_INDEX]; addr[1:0] ignored.
//  States: IDLE, LOOKUP, MISS, FILL, RESP, FLUSH.
//  IDLE
//   - cpu_req_ready=1 only in IDLE with flush_req=0.
//   - req_valid&&ready: latch addr -> LOOKUP.
//   - flush_req=1 -> FLUSH, counter=0. Flush has priority over a simultaneous request
//     (request not accepted).
//  LOOKUP
//   - tag_index = latched index.
//   - hit = tag_valid_out && tag_out==latched tag.
//   - Hit: cpu_resp_valid=1, cpu_resp_data=dat_rdata, hit_cnt++, -> IDLE.
//     Hit latency is 1 cycle after acceptance.
//   - Miss: miss_cnt++ -> MISS.
//  MISS
//   - mem_req=1, mem_addr={addr[ADDR_W-1:2],2'b00}, held stable until mem_ack.
//   - On mem_ack: latch mem_rdata -> FILL. mem_ack outside MISS is ignored.
//  FILL
//   - tag_we=1, dat_we=1, tag_valid_in=1, tag_in=latched tag, dat_wdata=latched data -> RESP.
//  RESP
//   - cpu_resp_valid=1, cpu_resp_data=latched data -> IDLE.
//   - Miss latency = 4 + memory wait cycles.
//  FLUSH
//   - Each cycle: tag_we=1, tag_valid_in=0, tag_in=0, tag_index=counter; counter++.
//   - After index `ICACHE_SIZE-1 is written: flush_done=1 -> IDLE.
//   - Duration = `ICACHE_SIZE cycles. flush_req ignored while in FLUSH.
//  Defaults: tag_we, dat_we, mem_req, cpu_resp_valid and flush_done are 0 outside their states.
//  Counters: saturate at all-ones, no wrap.
//  Reset (any state, including mid-miss or mid-flush):
//   - state=IDLE.
//   - All strobes=0. mem_req drops next edge; a late mem_ack is ignored.
//   - hit_cnt=miss_cnt=0. mem_addr, cpu_resp_data and tag_index=0.
//   - Tag RAM contents are not cleared by rst; invalidation is by flush only.
// STRUCTURE
//  Package icache_pkg: state enum icache_state_t, tag/index extraction functions.
//  No sub-module; single FSM plus latch registers and two counters.
// TESTING
//  - Cold miss: flush, then req 0x0000_0100, mem_ack after 3 cycles with 0xDEAD_BEEF
//    -> tag/data written at the index; resp 0xDEAD_BEEF 7 cycles after accept; miss_cnt=1.
//  - Hit: repeat 0x0000_0100 -> resp 0xDEAD_BEEF 1 cycle after accept; no mem_req; hit_cnt=1.
//  - Conflict: address with same index, different tag -> miss; line replaced;
//    original address then misses again.
//  - Flush + simultaneous req: cpu_req_ready=0 in that cycle; exactly `ICACHE_SIZE tag writes
//    with valid=0; flush_done pulses once; next req to 0x100 misses.
//  - Reset in MISS with mem_req=1 -> next cycle mem_req=0, IDLE, counters 0;
//    stray mem_ack produces no resp or write.
//  - Saturation: preload/force hit_cnt to all-ones, then issue a hit -> hit_cnt stays all-ones.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// Geometry: 16 one-word lines, byte address split as tag[31:6] | index[5:2] | byte[1:0].
package icache_pkg;

  localparam int ICACHE_INDEX = 4;
  localparam int ICACHE_SIZE  = 1 << ICACHE_INDEX;
  localparam int ITAGLSB      = ICACHE_INDEX + 2;
  localparam int ITAGMSB      = 31;
  localparam int TAG_W        = ITAGMSB - ITAGLSB + 1;
  localparam int WADDR_W      = ITAGMSB - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_FILL,
    S_RESP,
    S_FLUSH
  } icache_state_t;

  // Helpers take the word address (byte address >> 2), so every bit they see is used.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [WADDR_W-1:0] waddr);
    return waddr[WADDR_W-1:ITAGLSB-2];
  endfunction

  function automatic logic [ICACHE_INDEX-1:0] addr_index(input logic [WADDR_W-1:0] waddr);
    return waddr[ITAGLSB-3 -: ICACHE_INDEX];
  endfunction

endpackage

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped instruction-cache controller: tag compare on fetch, single-line refill
// from memory on a miss, whole-cache invalidation on flush, saturating hit/miss counters.
//
// Handshakes: a fetch is accepted on a rising edge where cpu_req_valid && cpu_req_ready;
// cpu_resp_valid is a one-cycle pulse with no backpressure. mem_req is a level held with
// a stable mem_addr until the edge where mem_ack is high; mem_ack outside MISS is ignored.
module inst_cache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic [ADDR_W-1:0]       cpu_req_addr,
  output logic                    cpu_resp_valid,
  output logic [DATA_W-1:0]       cpu_resp_data,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    tag_we,
  output logic [ICACHE_INDEX-1:0] tag_index,
  output logic                    tag_valid_in,
  output logic [TAG_W-1:0]        tag_in,
  input  logic                    tag_valid_out,
  input  logic [TAG_W-1:0]        tag_out,
  output logic                    dat_we,
  output logic [DATA_W-1:0]       dat_wdata,
  input  logic [DATA_W-1:0]       dat_rdata,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt,
  output icache_state_t           dbg_state_o
);

  icache_state_t           state_q, state_d;
  logic [ADDR_W-3:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0]       line_q, line_d;
  logic [ICACHE_INDEX-1:0] flush_cnt_q, flush_cnt_d;
  logic                    flush_done_q, flush_done_d;
  logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;
  logic                    lookup_hit;
  logic                    unused_addr_lsb;

  // Fetches are word granular; the byte offset never reaches the cache.
  assign unused_addr_lsb = ^cpu_req_addr[1:0];

  assign lookup_hit = (state_q == S_LOOKUP) && tag_valid_out &&
                      (tag_out == addr_tag(waddr_q));

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    line_d       = line_q;
    flush_cnt_d  = flush_cnt_q;
    flush_done_d = 1'b0;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end else if (cpu_req_valid) begin
          waddr_d = cpu_req_addr[ADDR_W-1:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          line_d    = dat_rdata;
          hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
          state_d   = S_IDLE;
        end else begin
          miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
          state_d    = S_MISS;
        end
      end
      S_MISS: begin
        if (mem_ack) begin
          line_d  = mem_rdata;
          state_d = S_FILL;
        end
      end
      S_FILL: state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        // The cache size is a power of two, so the last index is all-ones.
        if (&flush_cnt_q) begin
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      waddr_q      <= '0;
      line_q       <= '0;
      flush_cnt_q  <= '0;
      flush_done_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      line_q       <= line_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_done_q <= flush_done_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign cpu_req_ready  = (state_q == S_IDLE) && !flush_req;
  // A hit must answer in the lookup cycle, so its data bypasses the line register.
  assign cpu_resp_valid = lookup_hit || (state_q == S_RESP);
  assign cpu_resp_data  = lookup_hit ? dat_rdata : line_q;
  assign flush_done     = flush_done_q;

  assign tag_we       = (state_q == S_FILL) || (state_q == S_FLUSH);
  assign dat_we       = (state_q == S_FILL);
  assign tag_valid_in = (state_q == S_FILL);
  assign tag_in       = (state_q == S_FILL) ? addr_tag(waddr_q) : '0;
  assign tag_index    = (state_q == S_FLUSH) ? flush_cnt_q : addr_index(waddr_q);
  assign dat_wdata    = line_q;

  assign mem_req  = (state_q == S_MISS);
  assign mem_addr = {waddr_q, 2'b00};

  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Bench for inst_cache_ctrl: behavioural tag/data RAM, directed fetch/flush/reset steps,
// response scoreboard with expected data and latency, second instance for counter saturation.
module tb_inst_cache_ctrl;
  import icache_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int SW = 2;
  localparam logic [TAG_W-1:0] S_TAG  = TAG_W'(4);
  localparam logic [DW-1:0]    S_DATA = 32'h0BAD_CAFE;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic                    cpu_req_valid = 1'b0;
  logic                    cpu_req_ready;
  logic [AW-1:0]           cpu_req_addr = '0;
  logic                    cpu_resp_valid;
  logic [DW-1:0]           cpu_resp_data;
  logic                    flush_req = 1'b0;
  logic                    flush_done;
  logic                    tag_we, tag_valid_in, tag_valid_out, dat_we, mem_req;
  logic [ICACHE_INDEX-1:0] tag_index;
  logic [TAG_W-1:0]        tag_in, tag_out;
  logic [DW-1:0]           dat_wdata, dat_rdata;
  logic [AW-1:0]           mem_addr;
  logic                    mem_ack = 1'b0;
  logic [DW-1:0]           mem_rdata = '0;
  logic [CW-1:0]           hit_cnt, miss_cnt;
  icache_state_t           dbg_state;

  inst_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .tag_we(tag_we), .tag_index(tag_index), .tag_valid_in(tag_valid_in), .tag_in(tag_in),
    .tag_valid_out(tag_valid_out), .tag_out(tag_out),
    .dat_we(dat_we), .dat_wdata(dat_wdata), .dat_rdata(dat_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state_o(dbg_state)
  );

  // Saturation instance: tag RAM always reports a valid match, so every fetch hits.
  logic                    s_valid = 1'b0;
  logic                    s_ready, s_resp_valid, s_flush_done, s_tag_we, s_tag_valid_in;
  logic                    s_dat_we, s_mem_req;
  logic [AW-1:0]           s_addr = 32'h100;
  logic [DW-1:0]           s_resp_data, s_dat_wdata;
  logic [ICACHE_INDEX-1:0] s_tag_index;
  logic [TAG_W-1:0]        s_tag_in;
  logic [AW-1:0]           s_mem_addr;
  logic [SW-1:0]           s_hit_cnt, s_miss_cnt;
  icache_state_t           s_state;

  inst_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(SW)) dut_sat (
    .clk(clk), .rst(rst),
    .cpu_req_valid(s_valid), .cpu_req_ready(s_ready), .cpu_req_addr(s_addr),
    .cpu_resp_valid(s_resp_valid), .cpu_resp_data(s_resp_data),
    .flush_req(1'b0), .flush_done(s_flush_done),
    .tag_we(s_tag_we), .tag_index(s_tag_index), .tag_valid_in(s_tag_valid_in), .tag_in(s_tag_in),
    .tag_valid_out(1'b1), .tag_out(S_TAG),
    .dat_we(s_dat_we), .dat_wdata(s_dat_wdata), .dat_rdata(S_DATA),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(1'b0), .mem_rdata(32'h0),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .dbg_state_o(s_state)
  );

  // Behavioural tag/data RAM: combinational read, write on posedge. Powers up with
  // every line valid and tagged 4 so that only a flush makes 0x100 a cold miss.
  logic             tram_v [ICACHE_SIZE];
  logic [TAG_W-1:0] tram_t [ICACHE_SIZE];
  logic [DW-1:0]    dram   [ICACHE_SIZE];
  assign tag_valid_out = tram_v[tag_index];
  assign tag_out       = tram_t[tag_index];
  assign dat_rdata     = dram[tag_index];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < ICACHE_SIZE; i++) begin
        tram_v[i] <= 1'b1;
        tram_t[i] <= TAG_W'(4);
        dram[i]   <= 32'hBAD0_0000 | DW'(i);
      end
    end else begin
      if (tag_we) begin
        tram_v[tag_index] <= tag_valid_in;
        tram_t[tag_index] <= tag_in;
      end
      if (dat_we) dram[tag_index] <= dat_wdata;
    end
  end

  // scoreboard
  int              tests = 0;
  int              fails = 0;
  logic [DW-1:0]   exp_q [$];
  int              lat_q [$];
  int              acc_cyc = 0;
  int              mreq_cycles = 0;
  int              flush_wr = 0;
  int              wr_cnt = 0;
  int              done_cnt = 0;
  int              done_cyc = 0;
  logic [DW-1:0]   mon_d;
  int              mon_l;
  logic            mdl_v [ICACHE_SIZE];
  logic [TAG_W-1:0] mdl_t [ICACHE_SIZE];
  int              exp_hits = 0;
  int              exp_miss = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $error("FAIL %s: observed no event within bound, expected event", name);
  endtask

  always @(negedge clk) begin
    if (cpu_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_resp: observed %h expected no response", cpu_resp_data);
      end else begin
        mon_d = exp_q.pop_front();
        mon_l = lat_q.pop_front();
        chk("resp_data", cpu_resp_data, mon_d);
        chk("resp_latency", cyc - acc_cyc, mon_l);
      end
    end
    if (mem_req === 1'b1) mreq_cycles++;
    if (tag_we === 1'b1 && tag_valid_in === 1'b0 && tag_in === '0) flush_wr++;
    if (tag_we === 1'b1 || dat_we === 1'b1) wr_cnt++;
    if (flush_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = {a[AW-1:2], 2'b00};
    if (w == 32'h100) return 32'hDEAD_BEEF;
    if (w == 32'h140) return 32'hCAFE_F00D;
    return w ^ 32'h5A5A_0F0F;
  endfunction

  // driver: one fetch, predicted hit/miss from the bench's own cache model
  task automatic fetch(input logic [AW-1:0] a, input int wt);
    logic [ICACHE_INDEX-1:0] idx;
    logic [TAG_W-1:0]        tg;
    logic                    miss;
    logic [DW-1:0]           d;
    int                      mr0;
    int                      n;
    idx  = a[ITAGLSB-1 -: ICACHE_INDEX];
    tg   = a[ITAGMSB:ITAGLSB];
    miss = !(mdl_v[idx] && mdl_t[idx] == tg);
    d    = mem_word(a);
    mr0  = mreq_cycles;
    exp_q.push_back(d);
    lat_q.push_back(miss ? 4 + wt : 1);
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    n = 0;
    while (!cpu_req_ready && n < 20) begin @(negedge clk); n++; end
    if (!cpu_req_ready) timeout("req_ready");
    acc_cyc = cyc;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    if (miss) begin
      exp_miss++;
      @(negedge clk);
      n = 0;
      while (!mem_req && n < 20) begin @(negedge clk); n++; end
      if (!mem_req) timeout("mem_req");
      else begin
        chk("mem_addr", mem_addr, {a[AW-1:2], 2'b00});
        repeat (wt) @(posedge clk);
        if (wt > 0) #1;
        mem_ack   = 1'b1;
        mem_rdata = d;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
      mdl_v[idx] = 1'b1;
      mdl_t[idx] = tg;
    end else begin
      exp_hits++;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      timeout("resp");
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
    if (!miss) chk("hit_no_mem_req", mreq_cycles, mr0);
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_miss);
  endtask

  task automatic do_flush(input logic with_req, input int hold);
    int fw0, dc0, fs, n, vcnt;
    fw0 = flush_wr;
    dc0 = done_cnt;
    @(negedge clk);
    flush_req = 1'b1;
    if (with_req) begin
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 32'h100;
    end
    #1 chk("ready_with_flush_req", cpu_req_ready, 1'b0);
    fs = cyc;
    repeat (hold) @(posedge clk);
    #1 flush_req = 1'b0;
    cpu_req_valid = 1'b0;
    n = 0;
    while (done_cnt == dc0 && n < 40) begin @(negedge clk); n++; end
    if (done_cnt == dc0) timeout("flush_done");
    repeat (3) @(negedge clk);
    chk("flush_invalidate_writes", flush_wr - fw0, ICACHE_SIZE);
    chk("flush_done_pulses", done_cnt - dc0, 1);
    chk("flush_duration", done_cyc - fs, ICACHE_SIZE + 1);
    vcnt = 0;
    for (int i = 0; i < ICACHE_SIZE; i++) if (tram_v[i] !== 1'b0) vcnt++;
    chk("valid_lines_after_flush", vcnt, 0);
    for (int i = 0; i < ICACHE_SIZE; i++) mdl_v[i] = 1'b0;
  endtask

  logic [AW-1:0] pool [4];
  int            w0;
  int            n;

  initial begin
    pool[0] = 32'h0000_0100;
    pool[1] = 32'h0000_0140;
    pool[2] = 32'h0000_1234;
    pool[3] = 32'h0000_2236;
    for (int i = 0; i < ICACHE_SIZE; i++) begin
      mdl_v[i] = 1'b1;
      mdl_t[i] = TAG_W'(4);
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_ready", cpu_req_ready, 1'b1);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_tag_index", tag_index, 0);
    chk("rst_resp_data", cpu_resp_data, 0);
    chk("rst_strobes", {tag_we, dat_we, cpu_resp_valid, flush_done}, 4'b0000);

    // flush with a simultaneous fetch, then cold miss / hit / conflict
    do_flush(1'b1, 1);
    fetch(32'h0000_0100, 3);
    chk("fill_tag_valid", tram_v[0], 1'b1);
    chk("fill_tag", tram_t[0], TAG_W'(4));
    chk("fill_data", dram[0], 32'hDEAD_BEEF);
    fetch(32'h0000_0100, 0);
    fetch(32'h0000_0103, 0);
    fetch(32'h0000_0140, 0);
    chk("conflict_data", dram[0], 32'hCAFE_F00D);
    chk("conflict_tag", tram_t[0], TAG_W'(5));
    fetch(32'h0000_0100, 1);

    for (int i = 0; i < 8; i++) fetch(pool[$urandom_range(0, 3)], $urandom_range(0, 4));

    // flush request held for several cycles is not re-taken; 0x100 then misses
    do_flush(1'b0, 6);
    fetch(32'h0000_0100, 2);

    // reset while a refill is outstanding
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_0200;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    if (!mem_req) timeout("mid_miss_mem_req");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    @(negedge clk);
    chk("rst_miss_mem_req", mem_req, 1'b0);
    chk("rst_miss_state", dbg_state, S_IDLE);
    chk("rst_miss_hit_cnt", hit_cnt, 0);
    chk("rst_miss_miss_cnt", miss_cnt, 0);
    chk("rst_miss_mem_addr", mem_addr, 0);
    w0 = wr_cnt;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_writes", wr_cnt - w0, 0);
    chk("stray_ack_state", dbg_state, S_IDLE);
    chk("stray_ack_no_resp", exp_q.size(), 0);
    fetch(32'h0000_0200, 0);
    fetch(32'h0000_0200, 0);

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      chk("sat_ready", s_ready, 1'b1);
      @(posedge clk);
      #1 s_valid = 1'b0;
      @(negedge clk);
      chk("sat_resp_valid", s_resp_valid, 1'b1);
      chk("sat_resp_data", s_resp_data, S_DATA);
      @(posedge clk);
      #1 chk("sat_hit_cnt", s_hit_cnt, (i + 1 > 3) ? 3 : i + 1);
    end
    chk("sat_miss_cnt", s_miss_cnt, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
